re_tx_pkt_fifo: RTL and testbench

- Store-and-forward packet FIFO on the retransmit (RE) TX path, directly upstream of the RE-priority TX mux.
- The downstream mux gives RE priority whenever RE tvalid is high, so RE tvalid must never assert while a CU packet is mid-flight, and it must stay high through a whole packet.
- This block enforces both rules:
  - it buffers complete packets only;
  - it monitors the CU stream and starts a packet only on a CU packet boundary.

---
 rtl/tx_path_pkg.sv | 13 +
 rtl/simple_dp_ram.sv | 24 ++
 rtl/re_tx_pkt_fifo.sv | 143 ++++++++++++++
 tb/tb_re_tx_pkt_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_path_pkg.sv
// Shared TX-path definitions: default AXIS widths and the packet FIFO write-side state.
package tx_path_pkg;
  localparam int AXIS_DATA_W = 512;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
  localparam int AXIS_ID_W   = 10;
  localparam int AXIS_DEST_W = 4;
  localparam int AXIS_USER_W = 232;

  typedef enum logic {
    WRITE = 1'b0,
    DROP  = 1'b1
  } fifo_state_e;
endpackage

// File: rtl/simple_dp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// rd_data_o holds its value while rd_en_i is low, so it can act as a prefetch register.
module simple_dp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/re_tx_pkt_fifo.sv
// Store-and-forward RE packet FIFO ahead of the RE-priority TX mux. Releases a packet only when
// it is fully stored and the CU stream is on a packet boundary; oversize packets are dropped.
module re_tx_pkt_fifo
  import tx_path_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH    = AXIS_DATA_W,
  parameter int AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_TX_ID_WIDTH   = AXIS_ID_W,
  parameter int AXIS_TX_DEST_WIDTH = AXIS_DEST_W,
  parameter int AXIS_TX_USER_WIDTH = AXIS_USER_W,
  parameter int DEPTH              = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  input  logic [AXIS_TX_ID_WIDTH-1:0]   s_axis_tid,
  input  logic [AXIS_TX_DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [AXIS_TX_USER_WIDTH-1:0] s_axis_tuser,
  output logic                          s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [AXIS_TX_ID_WIDTH-1:0]   m_axis_tid,
  output logic [AXIS_TX_DEST_WIDTH-1:0] m_axis_tdest,
  output logic [AXIS_TX_USER_WIDTH-1:0] m_axis_tuser,
  input  logic                          m_axis_tready,
  input  logic                          mon_cu_tvalid,
  input  logic                          mon_cu_tready,
  input  logic                          mon_cu_tlast,
  output logic                          drop_pulse,
  output logic [$clog2(DEPTH):0]        pkt_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 1 + AXIS_TX_ID_WIDTH
                    + AXIS_TX_DEST_WIDTH + AXIS_TX_USER_WIDTH;

  fifo_state_e   state_q;
  logic [PW-1:0] wr_ptr_q, commit_ptr_q, rd_ptr_q, rd_addr_q;
  logic [PW-1:0] pkt_count_q, pkt_count_d;
  logic          en_q, drop_pulse_q, cu_mid_q, out_active_q, head_valid_q;
  logic          full, drop_now, s_hs, wr_en, commit, m_hs, m_last_hs, rd_en;
  logic [BW-1:0] rd_data;

  // Occupancy counts the head register too (rd_ptr moves on output handshake, not on RAM read).
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign drop_now = (state_q == DROP) || (full && (pkt_count_q == '0));

  assign s_axis_tready = en_q && (!full || drop_now);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign wr_en         = s_hs && !drop_now;
  assign commit        = wr_en && s_axis_tlast;

  assign m_axis_tvalid = head_valid_q && (pkt_count_q != '0) && (out_active_q || !cu_mid_q);
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign m_last_hs     = m_hs && m_axis_tlast;

  // Only committed beats are prefetched, so a dropped packet never reaches the head register.
  assign rd_en = (rd_addr_q != commit_ptr_q) && (!head_valid_q || m_hs);

  always_comb begin
    pkt_count_d = pkt_count_q;
    case ({commit, m_last_hs})
      2'b10:   pkt_count_d = pkt_count_q + PW'(1);
      2'b01:   pkt_count_d = pkt_count_q - PW'(1);
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WRITE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      drop_pulse_q <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      en_q         <= 1'b1;
      drop_pulse_q <= 1'b0;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        if (s_axis_tlast) commit_ptr_q <= wr_ptr_q + PW'(1);
      end
      case (state_q)
        WRITE:
          if (s_hs && drop_now) begin
            if (s_axis_tlast) begin
              wr_ptr_q     <= commit_ptr_q;
              drop_pulse_q <= 1'b1;
            end else begin
              state_q <= DROP;
            end
          end
        DROP:
          if (s_hs && s_axis_tlast) begin
            state_q      <= WRITE;
            wr_ptr_q     <= commit_ptr_q;
            drop_pulse_q <= 1'b1;
          end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      rd_addr_q    <= '0;
      pkt_count_q  <= '0;
      head_valid_q <= 1'b0;
      out_active_q <= 1'b0;
      cu_mid_q     <= 1'b0;
    end else begin
      if (rd_en) rd_addr_q <= rd_addr_q + PW'(1);
      if (m_hs)  rd_ptr_q  <= rd_ptr_q + PW'(1);
      head_valid_q <= rd_en || (head_valid_q && !m_hs);
      pkt_count_q  <= pkt_count_d;
      if (m_last_hs)          out_active_q <= 1'b0;
      else if (m_axis_tvalid) out_active_q <= 1'b1;
      if (mon_cu_tvalid && mon_cu_tready) cu_mid_q <= !mon_cu_tlast;
    end
  end

  simple_dp_ram #(
    .WIDTH(BW),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk      (clk),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_ptr_q[AW-1:0]),
    .wr_data_i({s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser}),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr_q[AW-1:0]),
    .rd_data_o(rd_data)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = rd_data;
  assign drop_pulse = drop_pulse_q;
  assign pkt_count  = pkt_count_q;
endmodule

// File: tb/tb_re_tx_pkt_fifo.sv
// Directed bench for re_tx_pkt_fifo: latency, CU-boundary gating, backpressure, drop, fill, reset.
module tb_re_tx_pkt_fifo;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int IW = 10;
  localparam int DSW = 4;
  localparam int UW = 232;
  localparam int DEPTH = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [DW-1:0]  s_axis_tdata = '0;
  logic [KW-1:0]  s_axis_tkeep = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tlast = 1'b0;
  logic [IW-1:0]  s_axis_tid = '0;
  logic [DSW-1:0] s_axis_tdest = '0;
  logic [UW-1:0]  s_axis_tuser = '0;
  logic           s_axis_tready;
  logic [DW-1:0]  m_axis_tdata;
  logic [KW-1:0]  m_axis_tkeep;
  logic           m_axis_tvalid;
  logic           m_axis_tlast;
  logic [IW-1:0]  m_axis_tid;
  logic [DSW-1:0] m_axis_tdest;
  logic [UW-1:0]  m_axis_tuser;
  logic           m_axis_tready = 1'b1;
  logic           mon_cu_tvalid = 1'b0;
  logic           mon_cu_tready;
  logic           mon_cu_tlast = 1'b0;
  logic           drop_pulse;
  logic [6:0]     pkt_count;

  // RE-priority mux model: CU is blocked whenever RE tvalid is high.
  assign mon_cu_tready = !m_axis_tvalid;

  always #5 clk = ~clk;

  re_tx_pkt_fifo #(
    .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_TX_ID_WIDTH(IW),
    .AXIS_TX_DEST_WIDTH(DSW), .AXIS_TX_USER_WIDTH(UW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest),
    .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .mon_cu_tvalid(mon_cu_tvalid), .mon_cu_tready(mon_cu_tready), .mon_cu_tlast(mon_cu_tlast),
    .drop_pulse(drop_pulse), .pkt_count(pkt_count)
  );

  int total = 0;
  int bad = 0;
  int cap_seed[$];
  bit cap_last[$];
  int bubble_cnt = 0, hold_err = 0, fld_err = 0, drop_cnt = 0;

  function automatic logic [DW-1:0] mk_data(input logic [31:0] s);
    return {16{s}};
  endfunction
  function automatic logic [KW-1:0] mk_keep(input logic [31:0] s);
    return {2{s}};
  endfunction
  function automatic logic [UW-1:0] mk_user(input logic [31:0] s);
    logic [255:0] t;
    t = {8{s}};
    return t[UW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled late in the low phase: captures beats that will handshake
  // on the coming edge and tracks bubbles, stall-hold and per-beat field integrity.
  logic          in_pkt = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    logic [31:0] sd;
    #4;
    if (!rst_n) begin
      in_pkt = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (drop_pulse) drop_cnt++;
      if (in_pkt && !m_axis_tvalid) bubble_cnt++;
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data)) hold_err++;
      if (m_axis_tvalid) begin
        sd = m_axis_tdata[31:0];
        if (m_axis_tdata !== mk_data(sd) || m_axis_tkeep !== mk_keep(sd) || m_axis_tid !== sd[IW-1:0] ||
            m_axis_tdest !== sd[DSW-1:0] || m_axis_tuser !== mk_user(sd)) fld_err++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap_seed.push_back(int'(m_axis_tdata[31:0]));
        cap_last.push_back(m_axis_tlast);
        in_pkt = !m_axis_tlast;
      end else if (m_axis_tvalid) begin
        in_pkt = 1'b1;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
    end
  end

  task automatic set_s(input int seed, input logic last);
    s_axis_tdata = mk_data(seed);
    s_axis_tkeep = mk_keep(seed);
    s_axis_tid   = seed[IW-1:0];
    s_axis_tdest = seed[DSW-1:0];
    s_axis_tuser = mk_user(seed);
    s_axis_tlast = last;
  endtask

  // Present one beat, wait (bounded) for ready, return at the negedge after the handshake.
  task automatic put(input int seed, input logic last);
    int n;
    n = 0;
    set_s(seed, last);
    s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) check($sformatf("put_stall_seed%0d", seed), s_axis_tready, 1);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    #1;
    while (!m_axis_tvalid && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check(tag, m_axis_tvalid, 1);
  endtask

  task automatic expect_pkt(input int first, input int n);
    check($sformatf("pkt%0d_avail", first), cap_seed.size() >= n, 1);
    for (int i = 0; i < n && cap_seed.size() > 0; i++) begin
      check($sformatf("pkt%0d_seed%0d", first, i), cap_seed.pop_front(), first + i);
      check($sformatf("pkt%0d_last%0d", first, i), cap_last.pop_front(), (i == n - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and tready release
    repeat (2) @(negedge clk);
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_drop_pulse", drop_pulse, 0);
    rst_n = 1'b1;
    #1;
    check("rel_s_tready_pre_edge", s_axis_tready, 0);
    @(negedge clk); #1;
    check("rel_s_tready_post_edge", s_axis_tready, 1);

    // 1: 3-beat packet, CU idle, latency N+2
    put(1, 0); put(2, 0); put(3, 1);
    #1;
    check("t1_tvalid_n1", m_axis_tvalid, 0);
    check("t1_pkt_count_n1", pkt_count, 1);
    @(negedge clk); #1;
    check("t1_tvalid_n2", m_axis_tvalid, 1);
    check("t1_pkt_count_n2", pkt_count, 1);
    repeat (4) @(negedge clk);
    #1;
    check("t1_pkt_count_end", pkt_count, 0);
    check("t1_tvalid_end", m_axis_tvalid, 0);
    expect_pkt(1, 3);

    // 2: CU mid-packet blocks RE until the cycle after CU tlast
    mon_cu_tvalid = 1'b1; mon_cu_tlast = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mon_cu_tvalid = 1'b0;
    put(10, 0); put(11, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check($sformatf("t2_gated_%0d", i), m_axis_tvalid, 0);
    end
    check("t2_pkt_count_gated", pkt_count, 1);
    mon_cu_tvalid = 1'b1; mon_cu_tlast = 1'b1;
    #1;
    check("t2_tvalid_cu_last_cycle", m_axis_tvalid, 0);
    @(negedge clk);
    mon_cu_tlast = 1'b0;
    #1;
    check("t2_tvalid_after_cu_last", m_axis_tvalid, 1);
    @(negedge clk); #1;
    check("t2_tvalid_beat2", m_axis_tvalid, 1);
    @(negedge clk); #1;
    check("t2_tvalid_done", m_axis_tvalid, 0);
    @(negedge clk);
    mon_cu_tvalid = 1'b0;
    expect_pkt(10, 2);
    put(12, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("t2_gated_b_%0d", i), m_axis_tvalid, 0);
    end
    check("t2_pkt_count_b", pkt_count, 1);
    mon_cu_tvalid = 1'b1; mon_cu_tlast = 1'b1;
    @(negedge clk);
    mon_cu_tvalid = 1'b0; mon_cu_tlast = 1'b0;
    #1;
    check("t2_tvalid_b_release", m_axis_tvalid, 1);
    repeat (2) @(negedge clk);
    expect_pkt(12, 1);

    // 3: tready toggling 1010, tvalid continuous, data held
    m_axis_tready = 1'b0;
    put(20, 0); put(21, 0); put(22, 0); put(23, 1);
    wait_valid("t3_tvalid_rise");
    for (int i = 0; i < 8; i++) begin
      m_axis_tready = (i % 2 == 0);
      #1;
      check($sformatf("t3_tvalid_%0d", i), m_axis_tvalid, (i <= 6));
      @(negedge clk);
    end
    m_axis_tready = 1'b1;
    expect_pkt(20, 4);

    // 4: 70-beat packet dropped, following packet intact
    for (int i = 0; i < 69; i++) put(100 + i, 0);
    check("t4_no_drop_before_last", drop_cnt, 0);
    check("t4_pkt_count_mid", pkt_count, 0);
    put(169, 1);
    #1;
    check("t4_drop_pulse", drop_pulse, 1);
    check("t4_pkt_count", pkt_count, 0);
    @(negedge clk); #1;
    check("t4_drop_pulse_once", drop_pulse, 0);
    check("t4_tvalid", m_axis_tvalid, 0);
    put(200, 0); put(201, 1);
    repeat (5) @(negedge clk);
    expect_pkt(200, 2);
    check("t4_drop_cnt", drop_cnt, 1);

    // 5: simultaneous commit and output tlast with pkt_count=2
    m_axis_tready = 1'b0;
    put(30, 0); put(31, 1); put(32, 0); put(33, 1);
    repeat (3) @(negedge clk);
    #1;
    check("t5_pkt_count_pre", pkt_count, 2);
    check("t5_tvalid_pre", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    set_s(34, 0); s_axis_tvalid = 1'b1;
    #1;
    check("t5_s_tready", s_axis_tready, 1);
    @(negedge clk);
    set_s(35, 1);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    #1;
    check("t5_pkt_count_same", pkt_count, 2);
    repeat (8) @(negedge clk);
    expect_pkt(30, 2); expect_pkt(32, 2); expect_pkt(34, 2);
    check("t5_pkt_count_drained", pkt_count, 0);

    // 5b: 64 beats across 4 packets fills the FIFO, backpressure only
    m_axis_tready = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 16; b++) put(40 + p * 16 + b, (b == 15));
    set_s(99, 1); s_axis_tvalid = 1'b1;
    #1;
    check("t5_full_s_tready", s_axis_tready, 0);
    check("t5_full_pkt_count", pkt_count, 4);
    @(negedge clk); #1;
    check("t5_full_s_tready_hold", s_axis_tready, 0);
    check("t5_full_no_drop", drop_cnt, 1);
    s_axis_tvalid = 1'b0;

    // 6: reset mid-output, then normal latency
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("t6_tvalid_mid", m_axis_tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_tvalid_async", m_axis_tvalid, 0);
    check("t6_pkt_count_async", pkt_count, 0);
    check("t6_s_tready_async", s_axis_tready, 0);
    check("t6_beats_before_rst", cap_seed.size(), 3);
    cap_seed.delete(); cap_last.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    put(60, 0); put(61, 1);
    #1;
    check("t6_tvalid_n1", m_axis_tvalid, 0);
    @(negedge clk); #1;
    check("t6_tvalid_n2", m_axis_tvalid, 1);
    repeat (3) @(negedge clk);
    expect_pkt(60, 2);
    check("t6_pkt_count_end", pkt_count, 0);

    check("bubbles", bubble_cnt, 0);
    check("hold_errors", hold_err, 0);
    check("field_errors", fld_err, 0);
    check("stray_beats", cap_seed.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
